dmi_jtag_access: RTL and testbench
==================================

# dmi_jtag_access

DMI access engine in the JTAG clock domain. Owns the 41-bit `dmi` data register selected by the TAP. It shifts the register, decodes the operation on Update-DR, and issues it as a `dm::dmi_req_t` request/response handshake toward the clock-domain crossing. Busy and failure status is kept sticky for the debugger. It sits between the TAP/`dtm_registers` control strobes and the `dmi_req_o`/`dmi_resp_i` ports of `dmi_jtag`.

## Interface
- `AddrWidth`, default 7: DMI address bits (abits). Register width is AddrWidth+34 = 41.
- `tck_i` (in, 1): JTAG clock; the only clock. All state is on the rising edge.
- `trst_ni` (in, 1): asynchronous, active-low reset.
- `dmi_clear_i` (in, 1): synchronous dmihardreset/TAP-reset clear.
- `capture_i`, `shift_i`, `update_i` (in, 1 each): TAP DR-state strobes, one tck each.
- `dmi_select_i` (in, 1): IR selects the DMI register.
- `tdi_i` (in, 1): serial data in.
- `dmi_tdo_o` (out, 1): serial data out, equal to `dr_q[0]`.
- `dmi_error_o` (out, 2): sticky status. 0 = ok, 2 = failed, 3 = busy. Feeds `dtmcs.dmistat`.
- `dmi_req_o` (out, dm::dmi_req_t): {addr[6:0], op[1:0], data[31:0]}.
- `dmi_req_valid_o` (out, 1): request valid.
- `dmi_req_ready_i` (in, 1): downstream accepts the request.
- `dmi_resp_i` (in, dm::dmi_resp_t): {data[31:0], resp[1:0]}.
- `dmi_resp_valid_i` (in, 1): response valid.
- `dmi_resp_ready_o` (out, 1): response accepted.

## Operation
- Register layout `dr_q[40:0]` = {addr[40:34], data[33:2], op[1:0]}.
- Op codes: 0 = nop, 1 = read, 2 = write, 3 = reserved (treated as nop).
- Capture (`capture_i & dmi_select_i`): `dr_q` <= {addr_q, data_q, error_q}.
- Shift (`shift_i & dmi_select_i`): `dr_q` <= {tdi_i, dr_q[40:1]}, LSB first.
- FSM states: IDLE, READ, WAIT_READ, WRITE, WAIT_WRITE.
- IDLE, on `update_i & dmi_select_i` with `error_q == 0`:
  - `addr_q` <= dr[40:34].
  - op = 1: go to READ.
  - op = 2: `data_q` <= dr[33:2], go to WRITE.
  - op = 0 or 3: stay in IDLE.
- Any update while `error_q != 0`: no access is issued; addr_q and data_q are unchanged.
- READ / WRITE: `dmi_req_valid_o` = 1 with op 1 / 2, `addr_q`, `data_q`.
  - On `dmi_req_ready_i`, go to WAIT_READ / WAIT_WRITE.
  - Valid stays high and the payload stays stable until accepted.
- WAIT_READ / WAIT_WRITE: `dmi_resp_ready_o` = 1.
  - On `dmi_resp_valid_i`, return to IDLE.
  - In WAIT_READ only, `data_q` <= `resp.data`.
  - If `resp.resp != 0` and `error_q == 0`, set `error_q` <= 2.
- Busy: `(capture_i | update_i) & dmi_select_i` while the FSM is not IDLE sets `error_q` <= 3.
  - Busy overrides failed.
  - Capture in the same cycle loads op field 3.
- `error_q` clears only on `dmi_clear_i` or reset.
- `dmi_clear_i` has priority over everything. It forces IDLE and clears `error_q`, `addr_q`, `data_q` and `dr_q` to 0.
  - Any in-flight request is abandoned; the downstream CDC is cleared by the same signal.
- `dmi_error_o` = `error_q`.

## Timing
- Reset values: state IDLE, `dr_q`, `addr_q`, `data_q`, `error_q` all 0.
- Outputs after reset: `dmi_tdo_o` = 0, `dmi_req_valid_o` = 0, `dmi_resp_ready_o` = 0, `dmi_req_o` = 0, `dmi_error_o` = 0.
- `dmi_req_valid_o` and `dmi_resp_ready_o` decode registered state only; there is no combinational path from any input.
- Valid rises 1 tck after the update edge.
- Minimum read: update → valid (1) → ready (same cycle if ready is high) → WAIT_READ → resp_valid captured → IDLE. That is 3 tck with zero-latency downstream.
- A handshake completes on the edge where valid&ready or resp_valid&resp_ready are both high.
- Read data is visible at the next capture after return to IDLE.
- Simultaneous `dmi_clear_i` and handshake: clear wins, and the handshake is not recorded.
- Reset is asserted asynchronously and released synchronously to `tck_i` at system level.

## Test plan
- Read: shift {addr=0x11, data=0, op=1}, update. Expect valid with addr 0x11, op 1. Respond data=0xDEADBEEF, resp=0. Next capture expects {0x11, 0xDEADBEEF, 0}.
- Write: shift {addr=0x10, data=0x00000001, op=2}. Expect `dmi_req_o` = {0x10, 2, 0x1}. Respond resp=0. Capture expects op field 0.
- Busy: hold `dmi_req_ready_i` = 0, issue a read, then capture. Expect op field 3 and `dmi_error_o` = 3. A new update issues no request. Assert `dmi_clear_i`: error goes to 0, state goes to IDLE, valid goes to 0.
- Failed: read answered with resp=2. Expect `dmi_error_o` = 2. A following write update is ignored, with valid staying 0.
- Nop/reserved: updates with op=0 and op=3 never raise valid; addr_q is still latched.
- Async reset mid-WAIT_WRITE: all outputs go to 0 immediately, without waiting for a `tck_i` edge.

Source files
------------

// File: rtl/dmi_jtag_access.sv
// rtl/dmi_jtag_access.sv - DMI data register and access engine in the JTAG clock domain
//
// Owns the DMI data register selected by the TAP. The register is shifted
// LSB first, decoded on Update-DR and issued as a valid/ready request toward
// the clock-domain crossing. Busy and failed status is sticky until cleared.
//
// Ports:
//   tck_i, trst_ni          JTAG clock, async active-low reset
//   dmi_clear_i             dmihardreset / TAP reset, synchronous clear
//   capture_i, shift_i,
//   update_i, dmi_select_i  TAP DR-state strobes and IR select
//   tdi_i, dmi_tdo_o        serial data in / out
//   dmi_error_o             sticky status: 0 ok, 2 failed, 3 busy
//   dmi_req_o               {addr, op[1:0], data[31:0]}
//   dmi_req_valid_o/ready_i request handshake
//   dmi_resp_i              {data[31:0], resp[1:0]}
//   dmi_resp_valid_i/ready_o response handshake

module dmi_jtag_access #(
  parameter int unsigned AddrWidth = 7
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  dmi_clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  dmi_select_i,
  input  logic                  tdi_i,
  output logic                  dmi_tdo_o,
  output logic [1:0]            dmi_error_o,
  output logic [AddrWidth+33:0] dmi_req_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  input  logic [33:0]           dmi_resp_i,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ       = 3'd1,
    WAIT_READ  = 3'd2,
    WRITE      = 3'd3,
    WAIT_WRITE = 3'd4
  } state_e;

  state_e                 state_q;
  logic [DrWidth-1:0]     dr_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [31:0]            data_q;
  logic [1:0]             error_q;
  logic [1:0]             req_op;
  logic                   busy;

  // Any TAP access to the register while a transaction is outstanding is a
  // protocol violation from the debugger's point of view.
  assign busy = (state_q != IDLE);

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q <= IDLE;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 2'b00;
    end else if (dmi_clear_i) begin
      // Clear wins over any handshake in the same cycle; the CDC is flushed
      // by the same signal so abandoning the transaction is safe.
      state_q <= IDLE;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 2'b00;
    end else begin
      if (capture_i && dmi_select_i) begin
        // A capture while busy reports busy immediately, matching the
        // error_q update below.
        dr_q <= {addr_q, data_q, (busy ? 2'b11 : error_q)};
      end else if (shift_i && dmi_select_i) begin
        dr_q <= {tdi_i, dr_q[DrWidth-1:1]};
      end

      case (state_q)
        IDLE: begin
          if (update_i && dmi_select_i && (error_q == 2'b00)) begin
            addr_q <= dr_q[DrWidth-1:34];
            case (dr_q[1:0])
              2'd1: state_q <= READ;
              2'd2: begin
                data_q  <= dr_q[33:2];
                state_q <= WRITE;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        READ:  if (dmi_req_ready_i) state_q <= WAIT_READ;
        WRITE: if (dmi_req_ready_i) state_q <= WAIT_WRITE;
        WAIT_READ: begin
          if (dmi_resp_valid_i) begin
            data_q <= dmi_resp_i[33:2];
            if ((dmi_resp_i[1:0] != 2'b00) && (error_q == 2'b00)) error_q <= 2'b10;
            state_q <= IDLE;
          end
        end
        WAIT_WRITE: begin
          if (dmi_resp_valid_i) begin
            if ((dmi_resp_i[1:0] != 2'b00) && (error_q == 2'b00)) error_q <= 2'b10;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Placed last so busy overrides a failed response landing this cycle.
      if ((capture_i || update_i) && dmi_select_i && busy) error_q <= 2'b11;
    end
  end

  always_comb begin
    req_op = 2'b00;
    if (state_q == READ)  req_op = 2'b01;
    if (state_q == WRITE) req_op = 2'b10;
  end

  assign dmi_tdo_o        = dr_q[0];
  assign dmi_error_o      = error_q;
  assign dmi_req_o        = {addr_q, req_op, data_q};
  assign dmi_req_valid_o  = (state_q == READ) || (state_q == WRITE);
  assign dmi_resp_ready_o = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);

endmodule

// File: tb/tb_dmi_jtag_access.sv
// tb/tb_dmi_jtag_access.sv - directed self-checking bench for dmi_jtag_access

module tb_dmi_jtag_access;

  logic        tck = 1'b0;
  logic        trst_n = 1'b0;
  logic        dmi_clear = 1'b0;
  logic        capture = 1'b0;
  logic        shift = 1'b0;
  logic        update = 1'b0;
  logic        dmi_select = 1'b0;
  logic        tdi = 1'b0;
  logic        dmi_tdo;
  logic [1:0]  dmi_error;
  logic [40:0] dmi_req;
  logic        dmi_req_valid;
  logic        dmi_req_ready = 1'b0;
  logic [33:0] dmi_resp = '0;
  logic        dmi_resp_valid = 1'b0;
  logic        dmi_resp_ready;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  dmi_jtag_access #(.AddrWidth(7)) dut (
    .tck_i            (tck),
    .trst_ni          (trst_n),
    .dmi_clear_i      (dmi_clear),
    .capture_i        (capture),
    .shift_i          (shift),
    .update_i         (update),
    .dmi_select_i     (dmi_select),
    .tdi_i            (tdi),
    .dmi_tdo_o        (dmi_tdo),
    .dmi_error_o      (dmi_error),
    .dmi_req_o        (dmi_req),
    .dmi_req_valid_o  (dmi_req_valid),
    .dmi_req_ready_i  (dmi_req_ready),
    .dmi_resp_i       (dmi_resp),
    .dmi_resp_valid_i (dmi_resp_valid),
    .dmi_resp_ready_o (dmi_resp_ready)
  );

  // Stimulus tasks are entered and left just after a falling edge.
  task automatic shift_dr(input logic [40:0] din, output logic [40:0] dout);
    for (int i = 0; i < 41; i++) begin
      dmi_select = 1'b1;
      shift      = 1'b1;
      tdi        = din[i];
      dout[i]    = dmi_tdo;
      @(negedge tck);
    end
    shift = 1'b0;
  endtask

  task automatic pulse_update();
    dmi_select = 1'b1;
    update     = 1'b1;
    @(negedge tck);
    update     = 1'b0;
  endtask

  task automatic pulse_capture();
    dmi_select = 1'b1;
    capture    = 1'b1;
    @(negedge tck);
    capture    = 1'b0;
  endtask

  task automatic pulse_clear();
    dmi_clear = 1'b1;
    @(negedge tck);
    dmi_clear = 1'b0;
  endtask

  task automatic test_reset();
    trst_n = 1'b0;
    @(negedge tck);
    checks++;
    if ({dmi_tdo, dmi_req_valid, dmi_resp_ready, dmi_error, dmi_req} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {dmi_tdo, dmi_req_valid, dmi_resp_ready, dmi_error, dmi_req});
    end
    trst_n = 1'b1;
    @(negedge tck);
  endtask

  task automatic test_read();
    logic [40:0] d;
    dmi_req_ready = 1'b0;
    shift_dr({7'h11, 32'h0, 2'd1}, d);
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b1 || dmi_req !== {7'h11, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL read_request: got valid=%b req=%h required valid=1 req=%h",
               dmi_req_valid, dmi_req, {7'h11, 2'd1, 32'h0});
    end
    dmi_req_ready = 1'b1;
    @(negedge tck);
    dmi_req_ready = 1'b0;
    checks++;
    if (dmi_resp_ready !== 1'b1 || dmi_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_wait: got resp_ready=%b valid=%b required 1 0", dmi_resp_ready, dmi_req_valid);
    end
    dmi_resp       = {32'hDEADBEEF, 2'd0};
    dmi_resp_valid = 1'b1;
    @(negedge tck);
    dmi_resp_valid = 1'b0;
    pulse_capture();
    shift_dr(41'd0, d);
    checks++;
    if (d !== {7'h11, 32'hDEADBEEF, 2'd0}) begin
      errors++;
      $display("FAIL read_capture: got %h required %h", d, {7'h11, 32'hDEADBEEF, 2'd0});
    end
  endtask

  task automatic test_write();
    logic [40:0] d;
    dmi_req_ready = 1'b0;
    shift_dr({7'h10, 32'h1, 2'd2}, d);
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b1 || dmi_req !== {7'h10, 2'd2, 32'h1}) begin
      errors++;
      $display("FAIL write_request: got valid=%b req=%h required valid=1 req=%h",
               dmi_req_valid, dmi_req, {7'h10, 2'd2, 32'h1});
    end
    @(negedge tck);
    checks++;
    if (dmi_req_valid !== 1'b1 || dmi_req !== {7'h10, 2'd2, 32'h1}) begin
      errors++;
      $display("FAIL write_hold: got valid=%b req=%h required valid=1 req=%h",
               dmi_req_valid, dmi_req, {7'h10, 2'd2, 32'h1});
    end
    dmi_req_ready = 1'b1;
    @(negedge tck);
    dmi_req_ready = 1'b0;
    dmi_resp       = {32'h0, 2'd0};
    dmi_resp_valid = 1'b1;
    @(negedge tck);
    dmi_resp_valid = 1'b0;
    pulse_capture();
    shift_dr(41'd0, d);
    checks++;
    if (d !== {7'h10, 32'h1, 2'd0}) begin
      errors++;
      $display("FAIL write_capture: got %h required %h", d, {7'h10, 32'h1, 2'd0});
    end
  endtask

  task automatic test_min_latency();
    logic [40:0] d;
    dmi_req_ready  = 1'b1;
    dmi_resp       = {32'hCAFEF00D, 2'd0};
    dmi_resp_valid = 1'b1;
    shift_dr({7'h12, 32'h0, 2'd1}, d);
    pulse_update();
    checks++;
    if ({dmi_req_valid, dmi_resp_ready} !== 2'b10) begin
      errors++;
      $display("FAIL latency_t1: got %b required 10", {dmi_req_valid, dmi_resp_ready});
    end
    @(negedge tck);
    checks++;
    if ({dmi_req_valid, dmi_resp_ready} !== 2'b01) begin
      errors++;
      $display("FAIL latency_t2: got %b required 01", {dmi_req_valid, dmi_resp_ready});
    end
    @(negedge tck);
    checks++;
    if ({dmi_req_valid, dmi_resp_ready} !== 2'b00) begin
      errors++;
      $display("FAIL latency_t3: got %b required 00", {dmi_req_valid, dmi_resp_ready});
    end
    dmi_resp_valid = 1'b0;
    dmi_req_ready  = 1'b0;
    pulse_capture();
    shift_dr(41'd0, d);
    checks++;
    if (d !== {7'h12, 32'hCAFEF00D, 2'd0}) begin
      errors++;
      $display("FAIL latency_capture: got %h required %h", d, {7'h12, 32'hCAFEF00D, 2'd0});
    end
  endtask

  task automatic test_busy();
    logic [40:0] d;
    dmi_req_ready = 1'b0;
    shift_dr({7'h05, 32'h0, 2'd1}, d);
    pulse_update();
    pulse_capture();
    checks++;
    if (dmi_error !== 2'd3) begin
      errors++;
      $display("FAIL busy_error: got %0d required 3", dmi_error);
    end
    shift_dr({7'h06, 32'h7, 2'd2}, d);
    checks++;
    if (d[1:0] !== 2'd3 || d[40:34] !== 7'h05) begin
      errors++;
      $display("FAIL busy_capture: got addr=%h op=%0d required addr=05 op=3", d[40:34], d[1:0]);
    end
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b1 || dmi_req[40:32] !== {7'h05, 2'd1}) begin
      errors++;
      $display("FAIL busy_no_new_request: got valid=%b addr_op=%h required valid=1 addr_op=%h",
               dmi_req_valid, dmi_req[40:32], {7'h05, 2'd1});
    end
    pulse_clear();
    checks++;
    if (dmi_error !== 2'd0 || dmi_req_valid !== 1'b0 || dmi_req !== 41'd0 || dmi_tdo !== 1'b0) begin
      errors++;
      $display("FAIL busy_clear: got err=%0d valid=%b req=%h tdo=%b required 0 0 0 0",
               dmi_error, dmi_req_valid, dmi_req, dmi_tdo);
    end
  endtask

  task automatic test_failed();
    logic [40:0] d;
    dmi_req_ready = 1'b1;
    shift_dr({7'h22, 32'h0, 2'd1}, d);
    pulse_update();
    @(negedge tck);
    dmi_req_ready  = 1'b0;
    dmi_resp       = {32'h12345678, 2'd2};
    dmi_resp_valid = 1'b1;
    @(negedge tck);
    dmi_resp_valid = 1'b0;
    checks++;
    if (dmi_error !== 2'd2) begin
      errors++;
      $display("FAIL failed_error: got %0d required 2", dmi_error);
    end
    dmi_req_ready = 1'b1;
    shift_dr({7'h30, 32'h0000AAAA, 2'd2}, d);
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL failed_ignore_t1: got valid=%b required 0", dmi_req_valid);
    end
    @(negedge tck);
    checks++;
    if (dmi_req_valid !== 1'b0 || dmi_req !== {7'h22, 2'd0, 32'h12345678} || dmi_error !== 2'd2) begin
      errors++;
      $display("FAIL failed_ignore_t2: got valid=%b req=%h err=%0d required 0 %h 2",
               dmi_req_valid, dmi_req, dmi_error, {7'h22, 2'd0, 32'h12345678});
    end
    dmi_req_ready = 1'b0;
    pulse_clear();
  endtask

  task automatic test_nop_reserved();
    logic [40:0] d;
    dmi_req_ready = 1'b1;
    shift_dr({7'h0A, 32'h55, 2'd0}, d);
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b0 || dmi_req !== {7'h0A, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL nop_op0: got valid=%b req=%h required 0 %h", dmi_req_valid, dmi_req, {7'h0A, 2'd0, 32'h0});
    end
    shift_dr({7'h0B, 32'h66, 2'd3}, d);
    pulse_update();
    checks++;
    if (dmi_req_valid !== 1'b0 || dmi_req !== {7'h0B, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL nop_op3: got valid=%b req=%h required 0 %h", dmi_req_valid, dmi_req, {7'h0B, 2'd0, 32'h0});
    end
    @(negedge tck);
    checks++;
    if (dmi_req_valid !== 1'b0 || dmi_error !== 2'd0) begin
      errors++;
      $display("FAIL nop_settle: got valid=%b err=%0d required 0 0", dmi_req_valid, dmi_error);
    end
    dmi_req_ready = 1'b0;
  endtask

  task automatic test_clear_race();
    logic [40:0] d;
    dmi_req_ready = 1'b1;
    shift_dr({7'h33, 32'h0, 2'd1}, d);
    pulse_update();
    @(negedge tck);
    dmi_req_ready  = 1'b0;
    dmi_resp       = {32'hFFFF0000, 2'd2};
    dmi_resp_valid = 1'b1;
    dmi_clear      = 1'b1;
    @(negedge tck);
    dmi_resp_valid = 1'b0;
    dmi_clear      = 1'b0;
    checks++;
    if (dmi_error !== 2'd0 || dmi_req !== 41'd0 || dmi_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_race: got err=%0d req=%h resp_ready=%b required 0 0 0",
               dmi_error, dmi_req, dmi_resp_ready);
    end
  endtask

  task automatic test_async_reset();
    logic [40:0] d;
    dmi_req_ready = 1'b1;
    shift_dr({7'h44, 32'h99, 2'd2}, d);
    pulse_update();
    @(negedge tck);
    dmi_req_ready = 1'b0;
    checks++;
    if (dmi_resp_ready !== 1'b1 || dmi_req !== {7'h44, 2'd0, 32'h99}) begin
      errors++;
      $display("FAIL async_pre_wait_write: got resp_ready=%b req=%h required 1 %h",
               dmi_resp_ready, dmi_req, {7'h44, 2'd0, 32'h99});
    end
    #2 trst_n = 1'b0;
    #1;
    checks++;
    if ({dmi_tdo, dmi_req_valid, dmi_resp_ready, dmi_error, dmi_req} !== 46'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0",
               {dmi_tdo, dmi_req_valid, dmi_resp_ready, dmi_error, dmi_req});
    end
    @(negedge tck);
    trst_n = 1'b1;
    @(negedge tck);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_min_latency();
    test_busy();
    test_failed();
    test_nop_reserved();
    test_clear_race();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
